// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: moves at most STEP bit positions per cycle
// between a valid/ready request port and a valid/ready result port.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// BUSY  | shifting the latched operand, up to STEP positions per cycle
// DONE  | Result valid; held until out_ready
module iter_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 8,
    parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            Shiftop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  busy
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    // STEP may equal DATA_WIDTH, which does not fit in AMT_WIDTH bits.
    localparam logic [AMT_WIDTH:0] STEP_W = (AMT_WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [AMT_WIDTH-1:0]    rem_q, rem_d;
    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   result_q;

    logic                    accept;
    logic                    last_step;
    logic [AMT_WIDTH-1:0]    step_amt;
    logic                    op_legal;
    logic [2*DATA_WIDTH-1:0] dbl;
    logic                    unused_b_hi;

    assign unused_b_hi = ^B[DATA_WIDTH-1:AMT_WIDTH];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_BUSY;
            S_BUSY:  if (last_step) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign accept = in_valid && in_ready;
    assign Result = result_q;

    // ---------------- datapath ----------------
    always_comb begin
        last_step = ({1'b0, rem_q} <= STEP_W);
        step_amt  = last_step ? rem_q : STEP_W[AMT_WIDTH-1:0];
        rem_d     = rem_q - step_amt;
        op_legal  = 1'b1;
        dbl       = '0;
        data_d    = data_q;
        case (op_q)
            OP_SLL: data_d = data_q << step_amt;
            OP_SRL: data_d = data_q >> step_amt;
            OP_SRA: data_d = $signed(data_q) >>> step_amt;
            OP_ROL: begin
                dbl    = {data_q, data_q} << step_amt;
                data_d = dbl[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            OP_ROR: begin
                dbl    = {data_q, data_q} >> step_amt;
                data_d = dbl[DATA_WIDTH-1:0];
            end
            default: op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            data_q <= A;
            rem_q  <= B[AMT_WIDTH-1:0];
            op_q   <= Shiftop;
        end else if (state_q == S_BUSY) begin
            data_q <= data_d;
            rem_q  <= rem_d;
            if (last_step) begin
                result_q <= op_legal ? data_d : '0;
            end
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Randomized + directed bench for iter_shifter against an arithmetic
// reference model of the shift/rotate result and latency.
module tb_iter_shifter;

    localparam int W    = 32;
    localparam int STEP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [2:0]    Shiftop;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Result;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    iter_shifter #(.DATA_WIDTH(W), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Shiftop   (Shiftop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input int n, input logic [2:0] op);
        case (op)
            3'b000:  return a << n;
            3'b010:  return a >> n;
            3'b011:  return 32'($signed(a) >>> n);
            3'b100:  return (n == 0) ? a : ((a << n) | (a >> (W - n)));
            3'b101:  return (n == 0) ? a : ((a >> n) | (a << (W - n)));
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input int n);
        return (n == 0) ? 1 : (n + STEP - 1) / STEP;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input int hold, input string tag);
        int          n;
        int          lat;
        int          cyc;
        logic [31:0] exp;
        n   = int'(b[4:0]);
        exp = model(a, n, op);
        lat = model_lat(n);

        A        = a;
        B        = b;
        Shiftop  = op;
        in_valid = 1'b1;
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        clk_step();
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        Shiftop  = 3'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);

        cyc = 0;
        while (!out_valid && cyc < 100) begin
            chk({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
            out_ready = 1'($urandom);
            clk_step();
            cyc++;
        end
        out_ready = 1'b0;
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_result"}, Result, exp);

        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            A        = $urandom;
            clk_step();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_result"}, Result, exp);
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        clk_step();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_drain_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Shiftop   = '0;
        repeat (3) clk_step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", Result, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rdy_after", 32'(in_ready), 32'd1);

        run_op(32'h0000_0001, 32'd31,        3'b000, 0, "sll31");
        run_op(32'h8000_0000, 32'hFFFF_FFE4, 3'b011, 0, "sra_mask");
        run_op(32'h8000_0000, 32'hFFFF_FFE4, 3'b010, 0, "srl_mask");
        run_op(32'h0000_00F1, 32'd4,         3'b101, 0, "ror4");
        run_op(32'h8000_0001, 32'd1,         3'b100, 0, "rol1");
        run_op(32'hDEAD_BEEF, 32'd0,         3'b000, 0, "zero_amt");
        run_op(32'hDEAD_BEEF, 32'd20,        3'b111, 0, "illegal");
        run_op(32'h1234_5678, 32'd8,         3'b100, 0, "rol8");
        run_op(32'h1234_5678, 32'd9,         3'b101, 0, "ror9");
        run_op(32'hCAFE_F00D, 32'd7,         3'b000, 5, "backpress");
        run_op(32'hFFFF_0000, 32'd16,        3'b010, 0, "srl16");

        // abort in the second BUSY cycle; no result may ever appear
        A        = 32'h0000_0001;
        B        = 32'd31;
        Shiftop  = 3'b000;
        in_valid = 1'b1;
        clk_step();
        in_valid = 1'b0;
        clk_step();
        rst = 1'b1;
        clk_step();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_result", Result, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_rdy", 32'(in_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            clk_step();
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 150; i++) begin
            run_op($urandom, $urandom, 3'($urandom), $urandom_range(0, 3), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised multi-cycle successor to the single-cycle combinational shifter in the ALU datapath.
- Performs logical left, logical right, arithmetic right, rotate left and rotate right on a DATA_WIDTH operand.
- Shifts at most STEP bit positions per cycle, so a smaller shift network can be traded for latency.
- Sits between the execute-stage issue logic and writeback, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of 2, >= 8.
- STEP, 8, maximum bit positions shifted per cycle; power of 2, 1..DATA_WIDTH.
- AMT_WIDTH, $clog2(DATA_WIDTH), width of the effective shift amount (derived; do not override).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- A  input  DATA_WIDTH  operand.
- B  input  DATA_WIDTH  shift amount; only B[AMT_WIDTH-1:0] used, upper bits ignored.
- Shiftop  input  3  000 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR; other codes illegal.
- out_valid  output  1  Result valid.
- out_ready  input  1  consumer takes Result.
- Result  output  DATA_WIDTH  registered result.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset: state=IDLE, out_valid=0, Result=0, busy=0. Internal data, remaining-count and op registers are cleared.
- in_ready = (state==IDLE) && !rst. This is combinational from state.
- IDLE:
  - On in_valid && in_ready, latch data=A, rem=B[AMT_WIDTH-1:0] and op=Shiftop, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each cycle:
  - s = min(rem, STEP).
  - data is shifted or rotated by s according to op; rem -= s.
  - If the pre-update rem <= STEP, go to DONE on this edge and load Result with the final shifted value.
- rem = 0 takes exactly one BUSY cycle with s=0; Result = A (SLL/SRL/SRA/ROL/ROR).
- Latency: out_valid rises max(1, ceil(n/STEP)) cycles after the acceptance edge, where n is the effective amount. Example: DATA_WIDTH=32, STEP=8: n=31 gives 4 cycles, n=8 gives 1, n=9 gives 2.
- Fill rules:
  - SLL and SRL fill with 0.
  - SRA fills with the sign bit of the current data. Since the sign never changes, this equals an arithmetic shift of A by n.
  - ROL/ROR rotate modulo DATA_WIDTH. Because n < DATA_WIDTH, no wrap correction is needed.
- Illegal Shiftop: same state sequence and latency rule; Result = 0.
- DONE:
  - out_valid=1; Result held stable and in_ready=0 until out_ready.
  - On out_valid && out_ready, go to IDLE with out_valid=0. Result keeps its value (don't-care once out_valid=0).
  - No same-edge acceptance of a new request: minimum 1 IDLE cycle between transactions.
- in_valid while not in_ready: ignored, no state change. The requester must hold the request until accepted.
- Input change while BUSY/DONE: no effect, since all operands were latched at acceptance.
- rst asserted in any state, including mid-BUSY or DONE with out_ready high: reset wins. On the next edge the block is in IDLE, out_valid=0, and the pending transaction is discarded with no output.
- out_ready while not out_valid: ignored.
- busy = (state != IDLE).

Test Plan:
- SLL, STEP=8: A=0x00000001, B=31, Shiftop=000 -> Result=0x80000000; out_valid 4 cycles after accept; in_ready=0 throughout.
- SRA and amount masking: A=0x80000000, B=0xFFFFFFE4 (effective 4), Shiftop=011 -> Result=0xF8000000 after 1 cycle. Same A/B with SRL (010) -> 0x08000000.
- Rotate: A=0x000000F1, B=4, ROR (101) -> 0x1000000F. A=0x80000001, B=1, ROL (100) -> 0x00000003. Both with 1-cycle latency.
- Zero amount and illegal op: A=0xDEADBEEF, B=0, SLL -> 0xDEADBEEF after 1 cycle. Shiftop=111 with B=20 -> Result=0 after 3 cycles.
- Backpressure: complete a shift with out_ready=0 for 5 cycles -> out_valid and Result stable, in_ready=0, concurrent in_valid ignored. Raise out_ready -> IDLE next edge, in_ready=1; then accept B=16 SRL on A=0xFFFF0000 -> 0x0000FFFF.
- Reset mid-operation: accept B=31 SLL, assert rst in the 2nd BUSY cycle -> next edge state IDLE, out_valid=0, Result=0, in_ready=1. Out_valid never pulses for the aborted request.
